// File: rtl/instruction_decode_stage_if.sv
// Bus between the decode stage and its neighbours: the fetch/writeback/MEM
// inputs, the combinational fetch controls and the ID/EX pipeline register.
interface instruction_decode_stage_if;
  logic [31:0] Instruction1;
  logic [31:0] PC1;
  logic        RegWriteWB;
  logic [4:0]  WriteRegWB;
  logic [31:0] WriteDataWB;
  logic        RegWriteMEM;
  logic        MemReadMEM;
  logic [4:0]  WriteRegMEM;
  logic [31:0] ALUResultMEM;
  logic        Stall;
  logic        PCsrc;
  logic [31:0] inMux;
  logic [31:0] ReadData1_2;
  logic [31:0] ReadData2_2;
  logic [31:0] SignExt2;
  logic [4:0]  Rs2;
  logic [4:0]  Rt2;
  logic [4:0]  Dest2;
  logic        RegWrite2;
  logic        MemtoReg2;
  logic        MemRead2;
  logic        MemWrite2;
  logic        ALUSrc2;
  logic [1:0]  ALUOp2;

  modport slave (
    input  Instruction1, PC1, RegWriteWB, WriteRegWB, WriteDataWB,
           RegWriteMEM, MemReadMEM, WriteRegMEM, ALUResultMEM,
    output Stall, PCsrc, inMux, ReadData1_2, ReadData2_2, SignExt2,
           Rs2, Rt2, Dest2, RegWrite2, MemtoReg2, MemRead2, MemWrite2,
           ALUSrc2, ALUOp2
  );

  modport master (
    output Instruction1, PC1, RegWriteWB, WriteRegWB, WriteDataWB,
           RegWriteMEM, MemReadMEM, WriteRegMEM, ALUResultMEM,
    input  Stall, PCsrc, inMux, ReadData1_2, ReadData2_2, SignExt2,
           Rs2, Rt2, Dest2, RegWrite2, MemtoReg2, MemRead2, MemWrite2,
           ALUSrc2, ALUOp2
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: register file, control decode, early beq/j resolution and
// hazard stall. Optional macro BRANCH_FWD_EN forwards MEM ALU results to the
// branch comparator instead of stalling.
module instruction_decode_stage (
  input logic                       CLK,
  input logic                       RST,
  instruction_decode_stage_if.slave bus
);
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  logic [DW-1:0] regs_q [NREG];

  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt, rd;
  logic [DW-1:0] sign_ext, pc_plus4, branch_tgt, jump_tgt;
  logic [DW-1:0] rd1, rd2, cmp_a, cmp_b;

  assign opcode   = bus.Instruction1[31:26];
  assign rs       = bus.Instruction1[25:21];
  assign rt       = bus.Instruction1[20:16];
  assign rd       = bus.Instruction1[15:11];
  assign sign_ext = {{16{bus.Instruction1[15]}}, bus.Instruction1[15:0]};
  assign pc_plus4   = bus.PC1 + DW'(4);
  assign branch_tgt = pc_plus4 + {sign_ext[DW-3:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], bus.Instruction1[25:0], 2'b00};

  // Register file; $0 is never written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.RegWriteWB && (bus.WriteRegWB != '0)) begin
      regs_q[bus.WriteRegWB] <= bus.WriteDataWB;
    end
  end

  // Reads see a same-cycle writeback to the same register.
  assign rd1 = (rs == '0) ? '0 :
               (bus.RegWriteWB && (bus.WriteRegWB == rs)) ? bus.WriteDataWB : regs_q[rs];
  assign rd2 = (rt == '0) ? '0 :
               (bus.RegWriteWB && (bus.WriteRegWB == rt)) ? bus.WriteDataWB : regs_q[rt];

  // Control decode
  logic          is_beq, is_j, uses_rt;
  logic          regwrite_c, memtoreg_c, memread_c, memwrite_c, alusrc_c;
  logic [1:0]    aluop_c;
  logic [AW-1:0] dest_c;

  always_comb begin
    regwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    alusrc_c   = 1'b0;
    aluop_c    = 2'b00;
    dest_c     = '0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    uses_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (bus.Instruction1 != '0) begin
          regwrite_c = 1'b1;
          aluop_c    = 2'b10;
          dest_c     = rd;
          uses_rt    = 1'b1;
        end
      end
      OP_LW: begin
        regwrite_c = 1'b1;
        memread_c  = 1'b1;
        memtoreg_c = 1'b1;
        alusrc_c   = 1'b1;
        dest_c     = rt;
      end
      OP_SW: begin
        memwrite_c = 1'b1;
        alusrc_c   = 1'b1;
        uses_rt    = 1'b1;
      end
      OP_ADDI: begin
        regwrite_c = 1'b1;
        alusrc_c   = 1'b1;
        dest_c     = rt;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  logic mem_hit_rs, mem_hit_rt;
  assign mem_hit_rs = (bus.WriteRegMEM != '0) && (bus.WriteRegMEM == rs);
  assign mem_hit_rt = (bus.WriteRegMEM != '0) && (bus.WriteRegMEM == rt);

`ifdef BRANCH_FWD_EN
  logic fwd_ok;
  assign fwd_ok = bus.RegWriteMEM && !bus.MemReadMEM;
  assign cmp_a  = (fwd_ok && mem_hit_rs) ? bus.ALUResultMEM : rd1;
  assign cmp_b  = (fwd_ok && mem_hit_rt) ? bus.ALUResultMEM : rd2;
  logic mem_alu_hazard;
  assign mem_alu_hazard = 1'b0;
`else
  logic unused_alu_result;
  assign unused_alu_result = ^bus.ALUResultMEM;
  assign cmp_a = rd1;
  assign cmp_b = rd2;
  logic mem_alu_hazard;
  assign mem_alu_hazard = is_beq && bus.RegWriteMEM && (mem_hit_rs || mem_hit_rt);
`endif

  // Hazard detection against the ID/EX and MEM occupants
  logic load_use, br_ex, br_mem_load, stall_c;
  assign load_use = bus.MemRead2 && (bus.Rt2 != '0) &&
                    ((bus.Rt2 == rs) || (uses_rt && (bus.Rt2 == rt)));
  assign br_ex    = is_beq && bus.RegWrite2 && (bus.Dest2 != '0) &&
                    ((bus.Dest2 == rs) || (bus.Dest2 == rt));
  assign br_mem_load = is_beq && bus.MemReadMEM && (mem_hit_rs || mem_hit_rt);
  assign stall_c  = load_use || br_ex || br_mem_load || mem_alu_hazard;

  assign bus.Stall = stall_c;
  assign bus.PCsrc = !stall_c && (is_j || (is_beq && (cmp_a == cmp_b)));
  assign bus.inMux = is_j ? jump_tgt : branch_tgt;

  // ID/EX pipeline register; a stall inserts an all-zero bubble.
  logic [DW-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, sext_q, sext_d;
  logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic          regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
  logic          memread_q, memread_d, memwrite_q, memwrite_d, alusrc_q, alusrc_d;
  logic [1:0]    aluop_q, aluop_d;

  always_comb begin
    rdata1_d   = '0;
    rdata2_d   = '0;
    sext_d     = '0;
    rs_d       = '0;
    rt_d       = '0;
    dest_d     = '0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    aluop_d    = 2'b00;
    if (!stall_c) begin
      rdata1_d   = rd1;
      rdata2_d   = rd2;
      sext_d     = sign_ext;
      rs_d       = rs;
      rt_d       = rt;
      dest_d     = dest_c;
      regwrite_d = regwrite_c;
      memtoreg_d = memtoreg_c;
      memread_d  = memread_c;
      memwrite_d = memwrite_c;
      alusrc_d   = alusrc_c;
      aluop_d    = aluop_c;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      sext_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= 2'b00;
    end else begin
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      sext_q     <= sext_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
    end
  end

  assign bus.ReadData1_2 = rdata1_q;
  assign bus.ReadData2_2 = rdata2_q;
  assign bus.SignExt2    = sext_q;
  assign bus.Rs2         = rs_q;
  assign bus.Rt2         = rt_q;
  assign bus.Dest2       = dest_q;
  assign bus.RegWrite2   = regwrite_q;
  assign bus.MemtoReg2   = memtoreg_q;
  assign bus.MemRead2    = memread_q;
  assign bus.MemWrite2   = memwrite_q;
  assign bus.ALUSrc2     = alusrc_q;
  assign bus.ALUOp2      = aluop_q;
endmodule
